// File: rtl/move_sequencer.sv
// Move sequencer: turns debounced direction presses into a timed scroll of the tile grid.
// Optional build macro MOVE_QUEUE_EN adds a one-entry press queue for presses made during a move.
module move_sequencer #(
  parameter int STEPS    = 6,
  parameter int TICK_DIV = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       up_enable,
  input  logic       down_enable,
  input  logic       left_enable,
  input  logic       right_enable,
  output logic [1:0] move_dir,
  output logic       move_active,
  output logic [2:0] scroll_step,
  output logic       step_pulse,
  output logic       move_done,
  output logic       move_rejected
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] TICK_PRE  = CNT_W'(TICK_DIV - 2);
  localparam logic [2:0]       STEP_LAST = 3'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCROLL = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] tick_q;
  logic [2:0]       scroll_step_q;
  logic [1:0]       move_dir_q;
  logic             move_active_q;
  logic             step_pulse_q;
  logic             move_done_q;
  logic             move_rejected_q;

  logic [3:0] btn_vec_s;
  logic [3:0] en_vec_s;
  logic       btn_any_s;
  logic [1:0] btn_dir_s;
  logic       req_valid_s;
  logic [1:0] req_dir_s;
  logic       req_en_s;

  // Fixed priority up > down > left > right; bit 0 of the vector is up.
  function automatic logic [1:0] pick_dir(input logic [3:0] btns);
    if (btns[0]) begin
      return 2'd0;
    end else if (btns[1]) begin
      return 2'd1;
    end else if (btns[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  assign btn_vec_s = {btn_right, btn_left, btn_down, btn_up};
  assign en_vec_s  = {right_enable, left_enable, down_enable, up_enable};
  assign btn_any_s = |btn_vec_s;
  assign btn_dir_s = pick_dir(btn_vec_s);

`ifdef MOVE_QUEUE_EN
  logic       q_valid_q;
  logic [1:0] q_dir_q;

  // Press queue: holds the first press seen while a move runs, emptied in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid_q <= 1'b0;
      q_dir_q   <= 2'd0;
    end else if (state_q == S_IDLE) begin
      q_valid_q <= 1'b0;
    end else if (!q_valid_q && btn_any_s) begin
      q_valid_q <= 1'b1;
      q_dir_q   <= btn_dir_s;
    end
  end

  // A queued press wins over a fresh press arriving in the same IDLE cycle.
  always_comb begin
    req_valid_s = 1'b0;
    req_dir_s   = 2'd0;
    if (q_valid_q) begin
      req_valid_s = 1'b1;
      req_dir_s   = q_dir_q;
    end else begin
      req_valid_s = btn_any_s;
      req_dir_s   = btn_dir_s;
    end
  end
`else
  // Only fresh presses are considered; presses during a move are discarded.
  always_comb begin
    req_valid_s = btn_any_s;
    req_dir_s   = btn_dir_s;
  end
`endif

  assign req_en_s = en_vec_s[req_dir_s];

  // Main sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      tick_q          <= '0;
      scroll_step_q   <= 3'd0;
      move_dir_q      <= 2'd0;
      move_active_q   <= 1'b0;
      step_pulse_q    <= 1'b0;
      move_done_q     <= 1'b0;
      move_rejected_q <= 1'b0;
    end else begin
      step_pulse_q    <= 1'b0;
      move_done_q     <= 1'b0;
      move_rejected_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tick_q        <= '0;
          scroll_step_q <= 3'd0;
          move_active_q <= 1'b0;
          if (req_valid_s) begin
            if (req_en_s) begin
              state_q       <= S_SCROLL;
              move_active_q <= 1'b1;
              move_dir_q    <= req_dir_s;
            end else begin
              move_rejected_q <= 1'b1;
            end
          end
        end
        S_SCROLL: begin
          // The strobe is raised one count early so it lands in the TICK_LAST cycle.
          if (tick_q == TICK_LAST) begin
            tick_q <= '0;
            if (scroll_step_q == STEP_LAST) begin
              state_q     <= S_SETTLE;
              move_done_q <= 1'b1;
            end else begin
              scroll_step_q <= scroll_step_q + 3'd1;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
            if (tick_q == TICK_PRE) begin
              step_pulse_q <= 1'b1;
            end
          end
        end
        S_SETTLE: begin
          state_q       <= S_IDLE;
          move_active_q <= 1'b0;
          scroll_step_q <= 3'd0;
          tick_q        <= '0;
        end
        default: begin
          state_q       <= S_IDLE;
          move_active_q <= 1'b0;
          scroll_step_q <= 3'd0;
          tick_q        <= '0;
        end
      endcase
    end
  end

  assign move_dir      = move_dir_q;
  assign move_active   = move_active_q;
  assign scroll_step   = scroll_step_q;
  assign step_pulse    = step_pulse_q;
  assign move_done     = move_done_q;
  assign move_rejected = move_rejected_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer (STEPS=6, TICK_DIV=4); follows MOVE_QUEUE_EN when defined.
module tb_move_sequencer;

  localparam int STEPS    = 6;
  localparam int TDIV     = 4;
  localparam int MOVE_LEN = STEPS * TDIV + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic up_enable = 1'b0, down_enable = 1'b0, left_enable = 1'b0, right_enable = 1'b0;
  logic [1:0] move_dir;
  logic       move_active;
  logic [2:0] scroll_step;
  logic       step_pulse;
  logic       move_done;
  logic       move_rejected;
  logic [8:0] obs;

  int checks = 0;
  int errors = 0;

  move_sequencer #(.STEPS(STEPS), .TICK_DIV(TDIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .up_enable(up_enable), .down_enable(down_enable),
    .left_enable(left_enable), .right_enable(right_enable),
    .move_dir(move_dir), .move_active(move_active), .scroll_step(scroll_step),
    .step_pulse(step_pulse), .move_done(move_done), .move_rejected(move_rejected)
  );

  always #5 clk = ~clk;

  // {dir[1:0], active, step[2:0], pulse, done, rejected}
  assign obs = {move_dir, move_active, scroll_step, step_pulse, move_done, move_rejected};

  typedef struct {
    logic [3:0] btn;   // {right, left, down, up}
    logic [3:0] en;    // {right, left, down, up}
    logic       acc;
    logic [1:0] dir;   // move_dir expected after the decision
  } vec_t;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_right, btn_left, btn_down, btn_up} = b;
  endtask

  task automatic set_en(input logic [3:0] e);
    {right_enable, left_enable, down_enable, up_enable} = e;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs d cycles after an accepted press in cycle N.
  function automatic logic [8:0] exp_move(input int d, input logic [1:0] dir);
    logic       act, pul, dn;
    logic [2:0] st;
    int         s;
    act = (d >= 1) && (d <= MOVE_LEN);
    pul = (d >= TDIV) && (d <= STEPS * TDIV) && ((d % TDIV) == 0);
    dn  = (d == MOVE_LEN);
    s   = act ? (d - 1) / TDIV : 0;
    if (s > STEPS - 1) s = STEPS - 1;
    st = 3'(s);
    return {dir, act, st, pul, dn, 1'b0};
  endfunction

  vec_t vecs[9];

  initial begin
    vecs[0] = '{btn: 4'b0001, en: 4'b1111, acc: 1'b1, dir: 2'd0};
    vecs[1] = '{btn: 4'b0010, en: 4'b1111, acc: 1'b1, dir: 2'd1};
    vecs[2] = '{btn: 4'b0100, en: 4'b1011, acc: 1'b0, dir: 2'd1};
    vecs[3] = '{btn: 4'b1000, en: 4'b1000, acc: 1'b1, dir: 2'd3};
    vecs[4] = '{btn: 4'b1001, en: 4'b1111, acc: 1'b1, dir: 2'd0};
    vecs[5] = '{btn: 4'b1001, en: 4'b1110, acc: 1'b0, dir: 2'd0};
    vecs[6] = '{btn: 4'b0110, en: 4'b0010, acc: 1'b1, dir: 2'd1};
    vecs[7] = '{btn: 4'b0110, en: 4'b1101, acc: 1'b0, dir: 2'd1};
    vecs[8] = '{btn: 4'b0100, en: 4'b0100, acc: 1'b1, dir: 2'd2};

    // Reset hold and quiet idle after release
    repeat (3) next_cycle();
    check("in_reset", obs, 9'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check($sformatf("idle_after_reset c=%0d", c), obs, 9'b0);
    end

    // Decision table: priority, enable sampling, reject strobe
    for (int i = 0; i < 9; i++) begin
      int dn_cnt;
      int k;
      next_cycle();
      set_btn(vecs[i].btn);
      set_en(vecs[i].en);
      next_cycle();
      set_btn(4'b0000);
      set_en(4'b0000);
      @(negedge clk);
      check($sformatf("vec%0d decide", i), obs,
            {vecs[i].dir, vecs[i].acc, 3'd0, 1'b0, 1'b0, ~vecs[i].acc});
      next_cycle();
      @(negedge clk);
      check($sformatf("vec%0d follow", i), obs,
            {vecs[i].dir, vecs[i].acc, 3'd0, 1'b0, 1'b0, 1'b0});
      if (vecs[i].acc) begin
        dn_cnt = 0;
        k = 0;
        while (move_active === 1'b1 && k < 100) begin
          next_cycle();
          @(negedge clk);
          if (move_done === 1'b1) dn_cnt++;
          k++;
        end
        check($sformatf("vec%0d done_once", i), 9'(dn_cnt), 9'd1);
        check($sformatf("vec%0d ended", i), {8'b0, move_active}, 9'b0);
      end
    end

    // Full move timeline; enable dropped mid-move must not abort
    next_cycle();
    set_btn(4'b0010);
    set_en(4'b0010);
    for (int d = 1; d <= 30; d++) begin
      next_cycle();
      set_btn(4'b0000);
      if (d == 3) set_en(4'b0000);
      @(negedge clk);
      check($sformatf("move d=%0d", d), obs, exp_move(d, 2'd1));
    end

    // Right press at d=10 during a down move
    next_cycle();
    set_btn(4'b0010);
    set_en(4'b1010);
    for (int d = 1; d <= 60; d++) begin
      logic [8:0] e;
      next_cycle();
      set_btn((d == 10) ? 4'b1000 : 4'b0000);
`ifdef MOVE_QUEUE_EN
      e = (d <= 26) ? exp_move(d, 2'd1) : exp_move(d - 26, 2'd3);
`else
      e = exp_move(d, 2'd1);
`endif
      @(negedge clk);
      check($sformatf("queue d=%0d", d), obs, e);
    end
    set_en(4'b0000);

    // Reset asserted mid-move
    next_cycle();
    set_btn(4'b0010);
    set_en(4'b0010);
    for (int d = 1; d <= 9; d++) begin
      next_cycle();
      set_btn(4'b0000);
      @(negedge clk);
      check($sformatf("pre_rst d=%0d", d), obs, exp_move(d, 2'd1));
    end
    next_cycle();
    rst_n = 1'b0;
    #1;
    check("rst_immediate", obs, 9'b0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check($sformatf("post_rst c=%0d", c), obs, 9'b0);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
